int_arbiter: RTL and testbench
==============================

# int_arbiter

Interrupt request arbiter placed ahead of the core-local interrupt controller. It latches asynchronous-interrupt events from NUM_SRC peripheral lines and gates them with the enable mask and mstatus.MIE. It selects one winner by fixed priority and presents it to the interrupt controller through a request/acknowledge handshake, so the interrupt controller only ever sees one stable asynchronous request at a time. An optional machine timer (mtime/mtimecmp) is built in as the highest-priority source.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters:
- NUM_SRC, 4: number of external interrupt lines (1..16).
- CAUSE_BASE, 16: exception code for source 0. Source k uses CAUSE_BASE+k.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-low reset.
- irq_i  input  NUM_SRC  interrupt lines, synchronous to clk; a rising edge creates an event.
- irq_en_i  input  NUM_SRC  per-source enable mask.
- csr_mstatus_i  input  64  current mstatus; bit 3 is MIE.
- clint_busy_i  input  1  the interrupt controller is sequencing CSR writes or a trap.
- int_ack_i  input  1  one-cycle pulse: the current request was taken.
- int_req_o  output  1  asynchronous interrupt request (drives the controller's global interrupt input).
- int_id_o  output  5  winning source id; 31 means the timer.
- int_cause_o  output  64  mcause value for the winner: {1'b1, 58'b0, code[4:0]}.
- pending_o  output  NUM_SRC  latched pending bits, for CSR mip readback.
- cmp_we_i  input  1  mtimecmp write strobe (TIMER_EN only).
- cmp_wdata_i  input  64  mtimecmp write data (TIMER_EN only).
- mtime_o  output  64  current mtime (TIMER_EN only).

## Operation
Pending logic:
- pending[k] sets on the cycle after a 0->1 transition of irq_i[k]. It clears on int_ack_i when int_id_o==k.
- If a set and a clear hit the same bit in the same cycle, set wins.
- Eligible sources: pending & irq_en_i, qualified by MIE.

Priority:
- Timer (when compiled in) ranks above every external line.
- Among external lines, the lowest index wins.

State machine (one-hot; reset state IDLE):
- IDLE -> REQ when any source is eligible, MIE=1 and clint_busy_i=0. The winner id and cause are registered on this transition.
- REQ holds int_req_o=1, with int_id_o and int_cause_o frozen. A higher-priority arrival does not preempt the request.
- REQ -> DRAIN on int_ack_i.
- REQ -> IDLE if MIE drops or the winner's enable drops before ack. The request is withdrawn and pending is kept.
- DRAIN -> IDLE on the first cycle with clint_busy_i=0. This guarantees one full idle cycle between consecutive trap entries.

Outputs:
- int_req_o=0 in IDLE and DRAIN.
- int_id_o and int_cause_o keep their last value outside REQ.

Arithmetic:
- code = CAUSE_BASE+k, truncated to 5 bits.
- Timer code is 7 (machine timer interrupt).

## Timing
- Reset values: int_req_o=0, int_id_o=0, int_cause_o=0, pending_o=0, mtime_o=0, mtimecmp=all ones, state=IDLE, edge-detect history=0.
- Reset mid-request drops int_req_o immediately (asynchronous) and discards all pending events.
- Edge on irq_i at cycle N: pending visible at N+1, int_req_o high at N+2 (minimum latency 2).
- int_ack_i is honoured only in REQ; in any other state it is ignored.
- Lowest ack-to-next-request spacing is 2 cycles (DRAIN then IDLE), even when clint_busy_i is never asserted.

## Configuration
- INT_ARB_TIMER_EN defined:
  - A 64-bit mtime counter increments every cycle and wraps from 2^64-1 to 0.
  - mtimecmp is loaded from cmp_wdata_i on cmp_we_i.
  - Timer pending is level, not latched: mtime >= mtimecmp (unsigned). Software clears it by writing a larger mtimecmp.
  - The timer is gated by MIE only (no irq_en_i bit). Its int_ack_i does not clear anything.
- INT_ARB_TIMER_EN undefined:
  - No timer logic is built.
  - mtime_o is tied to 0; cmp_we_i and cmp_wdata_i are unused.
  - int_id_o never equals 31.

## Test plan
- Single source: MIE=1, irq_en_i=4'b0100, pulse irq_i[2] at cycle 10 -> pending_o=4'b0100 at cycle 11; int_req_o=1, int_id_o=2, int_cause_o=0x8000_0000_0000_0012 at cycle 12; ack -> pending cleared and DRAIN.
- Priority and no preemption: raise irq_i[3], then irq_i[1] while in REQ for id 3 -> id stays 3 until ack; id 1 requested 2 cycles after ack.
- MIE gating: pending[0]=1 with MIE=0 -> int_req_o stays 0. MIE dropping in REQ -> int_req_o=0 next cycle and pending[0] still 1.
- Set/clear collision: a new edge on irq_i[1] in the same cycle as the ack for id 1 -> pending[1] remains 1 and is re-requested after DRAIN.
- Busy hold: clint_busy_i=1 for 5 cycles after ack -> DRAIN for 5 cycles, and no request until busy falls.
- Timer (INT_ARB_TIMER_EN): write mtimecmp=20 -> request id 31 with cause 0x8000_0000_0000_0007 when mtime reaches 20, with priority over a simultaneous irq_i[0]; rewriting mtimecmp=all ones clears the timer pending; async reset mid-REQ drops int_req_o at once.

Source files
------------

// File: rtl/int_arbiter.sv
// int_arbiter: latches peripheral interrupt edges, picks one fixed-priority winner and
// presents it to the CLINT over req/ack. Optional machine timer under INT_ARB_TIMER_EN.

module int_arbiter_lane (
  input  logic clk,
  input  logic rst,
  input  logic i_irq,
  input  logic i_clr,
  output logic o_pend
);
  logic r_hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= 1'b0;
      o_pend <= 1'b0;
    end else begin
      r_hist <= i_irq;
      // a fresh edge beats an ack clear landing in the same cycle
      o_pend <= (i_irq & ~r_hist) | (o_pend & ~i_clr);
    end
  end
endmodule

module int_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [NUM_SRC-1:0] irq_en_i,
  input  logic [63:0]        csr_mstatus_i,
  input  logic               clint_busy_i,
  input  logic               int_ack_i,
  output logic               int_req_o,
  output logic [4:0]         int_id_o,
  output logic [63:0]        int_cause_o,
  output logic [NUM_SRC-1:0] pending_o,
  input  logic               cmp_we_i,
  input  logic [63:0]        cmp_wdata_i,
  output logic [63:0]        mtime_o
);
  localparam logic [4:0] TIMER_ID   = 5'd31;
  localparam logic [4:0] TIMER_CODE = 5'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_REQ   = 3'b010,
    S_DRAIN = 3'b100
  } state_t;

  typedef struct packed {
    logic       any;
    logic [4:0] id;
    logic [4:0] code;
  } win_t;

  state_t             r_state;
  win_t               w_win;
  logic               w_mie;
  logic               w_ack;
  logic               w_tmr;
  logic               w_win_en;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_elig;

  assign w_mie     = csr_mstatus_i[3];
  assign w_ack     = int_ack_i && (r_state == S_REQ);
  assign w_elig    = w_pend & irq_en_i;
  assign pending_o = w_pend;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
    assign w_clr[k] = w_ack && (int_id_o == 5'(k));
    int_arbiter_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_irq  (irq_i[k]),
      .i_clr  (w_clr[k]),
      .o_pend (w_pend[k])
    );
  end

`ifdef INT_ARB_TIMER_EN
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        w_unused;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
    end else begin
      r_mtime <= r_mtime + 64'd1;
      if (cmp_we_i) r_mtimecmp <= cmp_wdata_i;
    end
  end

  // level-sensitive: stays up until software moves mtimecmp past mtime
  assign w_tmr    = (r_mtime >= r_mtimecmp);
  assign mtime_o  = r_mtime;
  assign w_unused = ^{csr_mstatus_i[63:4], csr_mstatus_i[2:0]};
`else
  logic w_unused;

  assign w_tmr    = 1'b0;
  assign mtime_o  = '0;
  assign w_unused = ^{csr_mstatus_i[63:4], csr_mstatus_i[2:0], cmp_we_i, cmp_wdata_i};
`endif

  // descending scan so the lowest index overwrites; timer overrides everything
  always_comb begin
    w_win = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_win.any  = 1'b1;
        w_win.id   = 5'(k);
        w_win.code = 5'(CAUSE_BASE + k);
      end
    end
    if (w_tmr) begin
      w_win.any  = 1'b1;
      w_win.id   = TIMER_ID;
      w_win.code = TIMER_CODE;
    end
  end

  always_comb begin
    w_win_en = (int_id_o == TIMER_ID);
    for (int k = 0; k < NUM_SRC; k++)
      if (int_id_o == 5'(k)) w_win_en = irq_en_i[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      int_req_o   <= 1'b0;
      int_id_o    <= '0;
      int_cause_o <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mie && !clint_busy_i && w_win.any) begin
            r_state     <= S_REQ;
            int_req_o   <= 1'b1;
            int_id_o    <= w_win.id;
            int_cause_o <= {1'b1, 58'b0, w_win.code};
          end
        end
        S_REQ: begin
          if (int_ack_i) begin
            r_state   <= S_DRAIN;
            int_req_o <= 1'b0;
          end else if (!w_mie || !w_win_en) begin
            r_state   <= S_IDLE;
            int_req_o <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (!clint_busy_i) r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          int_req_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (build with INT_ARB_TIMER_EN for timer tests).
module tb_int_arbiter;
  localparam int N  = 4;
  localparam int CB = 16;
  localparam int P_WAIT = 0, P_PRES = 1, P_COOL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  irq_i = '0, irq_en_i = '0;
  logic [63:0]   csr_mstatus_i = '0;
  logic          clint_busy_i = 1'b0, int_ack_i = 1'b0, cmp_we_i = 1'b0;
  logic [63:0]   cmp_wdata_i = '0;
  logic          int_req_o;
  logic [4:0]    int_id_o;
  logic [63:0]   int_cause_o, mtime_o;
  logic [N-1:0]  pending_o;

  int n_cmp = 0, n_bad = 0;

  int_arbiter #(.NUM_SRC(N), .CAUSE_BASE(CB)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .csr_mstatus_i(csr_mstatus_i), .clint_busy_i(clint_busy_i), .int_ack_i(int_ack_i),
    .int_req_o(int_req_o), .int_id_o(int_id_o), .int_cause_o(int_cause_o),
    .pending_o(pending_o), .cmp_we_i(cmp_we_i), .cmp_wdata_i(cmp_wdata_i), .mtime_o(mtime_o)
  );

  always #5 clk = ~clk;

  // reference model: pending set of events plus "who is being offered" bookkeeping
  logic [N-1:0] m_pend, m_prev;
  int           m_phase;
  logic [4:0]   m_id;
  logic [63:0]  m_cause, m_time, m_cmp;

  task automatic m_reset();
    m_pend = '0; m_prev = '0; m_phase = P_WAIT; m_id = '0; m_cause = '0;
    m_time = '0; m_cmp = '1;
  endtask

  task automatic m_step();
    logic [N-1:0] rise, clr, cand;
    logic         mie, tmr;
    int           win;
    rise = irq_i & ~m_prev;
    clr  = '0;
    mie  = csr_mstatus_i[3];
    cand = m_pend & irq_en_i;
    tmr  = 1'b0;
`ifdef INT_ARB_TIMER_EN
    tmr = (m_time >= m_cmp);
`endif
    case (m_phase)
      P_WAIT: if (mie && !clint_busy_i && (tmr || cand != '0)) begin
        if (tmr) begin
          m_id = 5'd31; m_cause = 64'h8000_0000_0000_0007;
        end else begin
          win = 0;
          for (int k = N - 1; k >= 0; k--) if (cand[k]) win = k;
          m_id = 5'(win);
          m_cause = {1'b1, 58'b0, 5'((CB + win) % 32)};
        end
        m_phase = P_PRES;
      end
      P_PRES: begin
        if (int_ack_i) begin
          if (m_id < 5'(N)) clr = {{(N-1){1'b0}}, 1'b1} << m_id;
          m_phase = P_COOL;
        end else if (!mie || (m_id != 5'd31 && ((irq_en_i >> m_id) & 1) == 0)) begin
          m_phase = P_WAIT;
        end
      end
      default: if (!clint_busy_i) m_phase = P_WAIT;
    endcase
    m_pend = (m_pend & ~clr) | rise;
    m_prev = irq_i;
`ifdef INT_ARB_TIMER_EN
    if (cmp_we_i) m_cmp = cmp_wdata_i;
    m_time = m_time + 64'd1;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b0;
    irq_i = '0; irq_en_i = '0; csr_mstatus_i = '0; clint_busy_i = 1'b0;
    int_ack_i = 1'b0; cmp_we_i = 1'b0; cmp_wdata_i = '0;
    m_reset();
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (int_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", int_req_o); end
    n_cmp++; if (int_id_o !== 5'd0) begin n_bad++; $display("FAIL rst_id: got %0d want 0", int_id_o); end
    n_cmp++; if (int_cause_o !== 64'd0) begin n_bad++; $display("FAIL rst_cause: got %h want 0", int_cause_o); end
    n_cmp++; if (pending_o !== '0) begin n_bad++; $display("FAIL rst_pend: got %b want 0", pending_o); end
    n_cmp++; if (mtime_o !== 64'd0) begin n_bad++; $display("FAIL rst_mtime: got %h want 0", mtime_o); end
    release_reset();
  endtask

  task automatic test_single_source();
    apply_reset(); release_reset();
    csr_mstatus_i = 64'h8; irq_en_i = 4'b0100;
    repeat (8) tick();
    irq_i[2] = 1'b1;
    tick();
    n_cmp++; if (pending_o !== 4'b0100 || int_req_o !== 1'b0) begin n_bad++;
      $display("FAIL single_pend: got pend=%b req=%b want 0100/0", pending_o, int_req_o); end
    irq_i[2] = 1'b0;
    tick();
    n_cmp++; if (int_req_o !== 1'b1 || int_id_o !== 5'd2) begin n_bad++;
      $display("FAIL single_req: got req=%b id=%0d want 1/2", int_req_o, int_id_o); end
    n_cmp++; if (int_cause_o !== 64'h8000_0000_0000_0012) begin n_bad++;
      $display("FAIL single_cause: got %h want 8000000000000012", int_cause_o); end
    tick();
    int_ack_i = 1'b1;
    tick();
    int_ack_i = 1'b0;
    n_cmp++; if (pending_o !== 4'b0000 || int_req_o !== 1'b0 || int_id_o !== 5'd2) begin n_bad++;
      $display("FAIL single_ack: got pend=%b req=%b id=%0d want 0000/0/2", pending_o, int_req_o, int_id_o); end
  endtask

  task automatic test_priority();
    apply_reset(); release_reset();
    csr_mstatus_i = 64'h8; irq_en_i = 4'b1111;
    irq_i[3] = 1'b1; tick();
    irq_i[1] = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (int_req_o !== 1'b1 || int_id_o !== 5'd3) begin n_bad++;
        $display("FAIL prio_hold%0d: got req=%b id=%0d want 1/3", i, int_req_o, int_id_o); end
      tick();
    end
    int_ack_i = 1'b1; tick();
    int_ack_i = 1'b0; irq_i = '0;
    n_cmp++; if (int_req_o !== 1'b0) begin n_bad++; $display("FAIL prio_drain: got %b want 0", int_req_o); end
    tick();
    n_cmp++; if (int_req_o !== 1'b0) begin n_bad++; $display("FAIL prio_idle: got %b want 0", int_req_o); end
    tick();
    n_cmp++; if (int_req_o !== 1'b1 || int_id_o !== 5'd1) begin n_bad++;
      $display("FAIL prio_next: got req=%b id=%0d want 1/1", int_req_o, int_id_o); end
  endtask

  task automatic test_mie_gating();
    apply_reset(); release_reset();
    irq_en_i = 4'b0001;
    irq_i[0] = 1'b1; tick(); irq_i[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (int_req_o !== 1'b0 || pending_o !== 4'b0001) begin n_bad++;
        $display("FAIL mie_off%0d: got req=%b pend=%b want 0/0001", i, int_req_o, pending_o); end
    end
    csr_mstatus_i = 64'h8; tick();
    n_cmp++; if (int_req_o !== 1'b1 || int_id_o !== 5'd0) begin n_bad++;
      $display("FAIL mie_on: got req=%b id=%0d want 1/0", int_req_o, int_id_o); end
    tick();
    csr_mstatus_i = 64'h0; tick();
    n_cmp++; if (int_req_o !== 1'b0 || pending_o !== 4'b0001) begin n_bad++;
      $display("FAIL mie_drop: got req=%b pend=%b want 0/0001", int_req_o, pending_o); end
  endtask

  task automatic test_collision_and_busy();
    apply_reset(); release_reset();
    csr_mstatus_i = 64'h8; irq_en_i = 4'b0010;
    irq_i[1] = 1'b1; tick(); irq_i[1] = 1'b0; tick();
    tick();
    int_ack_i = 1'b1; irq_i[1] = 1'b1; tick();
    int_ack_i = 1'b0; irq_i[1] = 1'b0;
    n_cmp++; if (pending_o !== 4'b0010 || int_req_o !== 1'b0) begin n_bad++;
      $display("FAIL collide_pend: got pend=%b req=%b want 0010/0", pending_o, int_req_o); end
    tick(); tick();
    n_cmp++; if (int_req_o !== 1'b1 || int_id_o !== 5'd1) begin n_bad++;
      $display("FAIL collide_rereq: got req=%b id=%0d want 1/1", int_req_o, int_id_o); end
    int_ack_i = 1'b1; clint_busy_i = 1'b1; tick();
    int_ack_i = 1'b0; irq_i[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (int_req_o !== 1'b0) begin n_bad++; $display("FAIL busy_hold%0d: got %b want 0", i, int_req_o); end
    end
    n_cmp++; if (pending_o !== 4'b0010) begin n_bad++; $display("FAIL busy_pend: got %b want 0010", pending_o); end
    clint_busy_i = 1'b0; irq_i[1] = 1'b0; tick();
    n_cmp++; if (int_req_o !== 1'b0) begin n_bad++; $display("FAIL busy_idle: got %b want 0", int_req_o); end
    tick();
    n_cmp++; if (int_req_o !== 1'b1 || int_id_o !== 5'd1) begin n_bad++;
      $display("FAIL busy_rereq: got req=%b id=%0d want 1/1", int_req_o, int_id_o); end
  endtask

  task automatic test_reset_mid_req();
    apply_reset(); release_reset();
    csr_mstatus_i = 64'h8; irq_en_i = 4'b1111;
    irq_i = 4'b0101; tick(); tick();
    n_cmp++; if (int_req_o !== 1'b1) begin n_bad++; $display("FAIL midrst_pre: got %b want 1", int_req_o); end
    #2 rst = 1'b0; #1;
    n_cmp++; if (int_req_o !== 1'b0 || pending_o !== '0) begin n_bad++;
      $display("FAIL midrst_drop: got req=%b pend=%b want 0/0000", int_req_o, pending_o); end
    apply_reset(); release_reset();
  endtask

  task automatic test_random();
    apply_reset(); release_reset();
    irq_en_i = 4'b1111; csr_mstatus_i = 64'h8;
    for (int c = 0; c < 600; c++) begin
      irq_i = irq_i ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 19) == 0) irq_en_i = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 14) == 0) csr_mstatus_i = {$urandom, $urandom};
      else if ($urandom_range(0, 9) == 0) csr_mstatus_i = 64'h8;
      clint_busy_i = ($urandom_range(0, 3) == 0);
      int_ack_i    = ($urandom_range(0, 2) == 0);
      cmp_we_i     = 1'b0;
`ifdef INT_ARB_TIMER_EN
      if ($urandom_range(0, 39) == 0) begin cmp_we_i = 1'b1; cmp_wdata_i = m_time + 64'($urandom_range(0, 30)); end
      else if ($urandom_range(0, 29) == 0) begin cmp_we_i = 1'b1; cmp_wdata_i = '1; end
`endif
      tick();
      n_cmp++; if (int_req_o !== (m_phase == P_PRES)) begin n_bad++;
        $display("FAIL rnd_req@%0d: got %b want %b", c, int_req_o, (m_phase == P_PRES)); end
      n_cmp++; if (int_id_o !== m_id || int_cause_o !== m_cause) begin n_bad++;
        $display("FAIL rnd_win@%0d: got id=%0d cause=%h want id=%0d cause=%h", c, int_id_o, int_cause_o, m_id, m_cause); end
      n_cmp++; if (pending_o !== m_pend) begin n_bad++;
        $display("FAIL rnd_pend@%0d: got %b want %b", c, pending_o, m_pend); end
      n_cmp++; if (mtime_o !== m_time) begin n_bad++;
        $display("FAIL rnd_mtime@%0d: got %h want %h", c, mtime_o, m_time); end
    end
    int_ack_i = 1'b0; clint_busy_i = 1'b0; cmp_we_i = 1'b0;
  endtask

`ifdef INT_ARB_TIMER_EN
  task automatic test_timer();
    apply_reset(); release_reset();
    csr_mstatus_i = 64'h8; irq_en_i = 4'b0001;
    cmp_we_i = 1'b1; cmp_wdata_i = 64'd20; tick(); cmp_we_i = 1'b0;
    for (int i = 0; i < 100 && mtime_o != 64'd19; i++) tick();
    n_cmp++; if (mtime_o !== 64'd19) begin n_bad++; $display("FAIL tmr_reach: got %h want 13", mtime_o); end
    irq_i[0] = 1'b1; tick(); irq_i[0] = 1'b0; tick();
    n_cmp++; if (int_req_o !== 1'b1 || int_id_o !== 5'd31) begin n_bad++;
      $display("FAIL tmr_win: got req=%b id=%0d want 1/31", int_req_o, int_id_o); end
    n_cmp++; if (int_cause_o !== 64'h8000_0000_0000_0007) begin n_bad++;
      $display("FAIL tmr_cause: got %h want 8000000000000007", int_cause_o); end
    int_ack_i = 1'b1; cmp_we_i = 1'b1; cmp_wdata_i = '1; tick();
    int_ack_i = 1'b0; cmp_we_i = 1'b0;
    n_cmp++; if (pending_o !== 4'b0001) begin n_bad++; $display("FAIL tmr_keep0: got %b want 0001", pending_o); end
    tick(); tick();
    n_cmp++; if (int_req_o !== 1'b1 || int_id_o !== 5'd0) begin n_bad++;
      $display("FAIL tmr_cleared: got req=%b id=%0d want 1/0", int_req_o, int_id_o); end
    #2 rst = 1'b0; #1;
    n_cmp++; if (int_req_o !== 1'b0 || mtime_o !== 64'd0) begin n_bad++;
      $display("FAIL tmr_rst: got req=%b mtime=%h want 0/0", int_req_o, mtime_o); end
    apply_reset(); release_reset();
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_single_source();
    test_priority();
    test_mie_gating();
    test_collision_and_busy();
    test_reset_mid_req();
`ifdef INT_ARB_TIMER_EN
    test_timer();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
